// File: rtl/rv_mop_crack.sv
// Macro-op cracker: re-expands fused load ops (ld.pc, ld.add, ld.shNadd) into two uops; others pass through.
// Latency: 1 cycle from input handshake to out_valid; cracked ops occupy the output for two uop slots.
// Backpressure: out_ready low freezes the output register and the pending uop2; in_ready drops while uop2 is held.
module rv_mop_crack (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        flush,

  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [32:0] in_imm,
  input  logic [1:0]  in_len_half_minus_one,

  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_opcode,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic [32:0] out_imm,
  output logic        out_first,
  output logic        out_last,
  output logic [1:0]  out_len_half_minus_one
);

  localparam logic [4:0] OPC_FUSED = 5'b00010;
  localparam logic [4:0] OPC_LOAD  = 5'b00000;
  localparam logic [4:0] OPC_AUIPC = 5'b00101;
  localparam logic [4:0] OPC_OP    = 5'b01100;

  localparam logic [6:0] F7_LD_PC     = 7'b0000000;
  localparam logic [6:0] F7_LD_ADD    = 7'b0000001;
  localparam logic [6:0] F7_LD_SH1ADD = 7'b0000010;
  localparam logic [6:0] F7_LD_SH2ADD = 7'b0000011;
  localparam logic [6:0] F7_LD_SH3ADD = 7'b0000100;
  localparam logic [6:0] F7_SHADD     = 7'b0010000;

  // IDLE: no uop2 held. SECOND: uop1 sits in the output register, uop2 waits behind it.
  typedef enum logic {S_IDLE, S_SECOND} state_e;

  state_e      state_q;

  // Output register.
  logic        out_valid_q;
  logic [4:0]  out_rd_q, out_rs1_q, out_rs2_q, out_opcode_q;
  logic [2:0]  out_funct3_q;
  logic [6:0]  out_funct7_q;
  logic [32:0] out_imm_q;
  logic        out_first_q, out_last_q;
  logic [1:0]  out_len_q;

  // Second-uop register: uop2 is always a load, so only its variable fields are kept.
  logic [4:0]  pend_rd_q;
  logic [2:0]  pend_funct3_q;
  logic [32:0] pend_imm_q;
  logic [1:0]  pend_len_q;

  // Decoded first uop (or the pass-through uop) and the variable part of uop2.
  logic        crack;
  logic [4:0]  u1_rs1, u1_rs2, u1_opcode;
  logic [2:0]  u1_funct3;
  logic [6:0]  u1_funct7;
  logic [32:0] u1_imm;
  logic [32:0] u2_imm;
  logic [20:0] auipc_hi;

  // Upper 21 bits of the pc-relative offset, rounded so that the load's signed low 12 bits land exactly.
  assign auipc_hi = in_imm[32:12] + {20'd0, in_imm[11]};

  // Crack decode: default is a verbatim copy, overridden for the five fused forms.
  always_comb begin
    crack     = 1'b0;
    u1_rs1    = in_rs1;
    u1_rs2    = in_rs2;
    u1_opcode = in_opcode;
    u1_funct3 = in_funct3;
    u1_funct7 = in_funct7;
    u1_imm    = in_imm;
    u2_imm    = 33'd0;
    if (in_opcode == OPC_FUSED) begin
      unique case (in_funct7)
        F7_LD_PC: begin
          crack     = 1'b1;
          u1_opcode = OPC_AUIPC;
          u1_rs1    = 5'd0;
          u1_rs2    = 5'd0;
          u1_funct3 = 3'b000;
          u1_funct7 = 7'd0;
          u1_imm    = {auipc_hi, 12'd0};
          u2_imm    = {{21{in_imm[11]}}, in_imm[11:0]};
        end
        F7_LD_ADD: begin
          crack     = 1'b1;
          u1_opcode = OPC_OP;
          u1_funct3 = 3'b000;
          u1_funct7 = 7'd0;
          u1_imm    = 33'd0;
        end
        F7_LD_SH1ADD: begin
          crack     = 1'b1;
          u1_opcode = OPC_OP;
          u1_funct3 = 3'b010;
          u1_funct7 = F7_SHADD;
          u1_imm    = 33'd0;
        end
        F7_LD_SH2ADD: begin
          crack     = 1'b1;
          u1_opcode = OPC_OP;
          u1_funct3 = 3'b100;
          u1_funct7 = F7_SHADD;
          u1_imm    = 33'd0;
        end
        F7_LD_SH3ADD: begin
          crack     = 1'b1;
          u1_opcode = OPC_OP;
          u1_funct3 = 3'b110;
          u1_funct7 = F7_SHADD;
          u1_imm    = 33'd0;
        end
        default: begin
          crack = 1'b0;
        end
      endcase
    end
  end

  // Accept only when no uop2 is waiting and the output slot is free or draining this cycle.
  assign in_ready = !flush && (state_q == S_IDLE) && (!out_valid_q || out_ready);

  // Output register and crack FSM: flush, then uop2 drain, then new op, then plain drain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      out_valid_q   <= 1'b0;
      out_rd_q      <= 5'd0;
      out_rs1_q     <= 5'd0;
      out_rs2_q     <= 5'd0;
      out_opcode_q  <= 5'd0;
      out_funct3_q  <= 3'd0;
      out_funct7_q  <= 7'd0;
      out_imm_q     <= 33'd0;
      out_first_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_len_q     <= 2'd0;
      pend_rd_q     <= 5'd0;
      pend_funct3_q <= 3'd0;
      pend_imm_q    <= 33'd0;
      pend_len_q    <= 2'd0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
      state_q     <= S_IDLE;
    end else if ((state_q == S_SECOND) && (!out_valid_q || out_ready)) begin
      out_valid_q  <= 1'b1;
      out_rd_q     <= pend_rd_q;
      out_rs1_q    <= pend_rd_q;
      out_rs2_q    <= 5'd0;
      out_opcode_q <= OPC_LOAD;
      out_funct3_q <= pend_funct3_q;
      out_funct7_q <= 7'd0;
      out_imm_q    <= pend_imm_q;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b1;
      out_len_q    <= pend_len_q;
      state_q      <= S_IDLE;
    end else if (in_valid && in_ready) begin
      out_valid_q  <= 1'b1;
      out_rd_q     <= in_rd;
      out_rs1_q    <= u1_rs1;
      out_rs2_q    <= u1_rs2;
      out_opcode_q <= u1_opcode;
      out_funct3_q <= u1_funct3;
      out_funct7_q <= u1_funct7;
      out_imm_q    <= u1_imm;
      out_first_q  <= 1'b1;
      out_last_q   <= !crack;
      out_len_q    <= crack ? 2'b00 : in_len_half_minus_one;
      if (crack) begin
        state_q       <= S_SECOND;
        pend_rd_q     <= in_rd;
        pend_funct3_q <= in_funct3;
        pend_imm_q    <= u2_imm;
        pend_len_q    <= in_len_half_minus_one;
      end
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid              = out_valid_q;
  assign out_rd                 = out_rd_q;
  assign out_rs1                = out_rs1_q;
  assign out_rs2                = out_rs2_q;
  assign out_opcode             = out_opcode_q;
  assign out_funct3             = out_funct3_q;
  assign out_funct7             = out_funct7_q;
  assign out_imm                = out_imm_q;
  assign out_first              = out_first_q;
  assign out_last               = out_last_q;
  assign out_len_half_minus_one = out_len_q;

endmodule

// File: tb/tb_rv_mop_crack.sv
// Bench for rv_mop_crack: directed scenarios with literal expectations, then randomized traffic.
// Expected uops come from a queue model built straight from the cracking rules.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_rv_mop_crack;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd, in_rs1, in_rs2, in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [32:0] in_imm;
  logic [1:0]  in_len_half_minus_one;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd, out_rs1, out_rs2, out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [32:0] out_imm;
  logic        out_first, out_last;
  logic [1:0]  out_len_half_minus_one;

  rv_mop_crack dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_imm(in_imm), .in_len_half_minus_one(in_len_half_minus_one),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_first(out_first), .out_last(out_last),
    .out_len_half_minus_one(out_len_half_minus_one)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [32:0] imm;
    logic        first;
    logic        last;
    logic [1:0]  len;
    logic        auipc;   // funct3/funct7 of an auipc uop are not defined, so they are not compared
  } uop_t;

  uop_t q[$];   // uops accepted but not yet handed downstream, oldest first
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the op turns into, straight from the cracking rules.
  function automatic void model_push(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [32:0] imm, input logic [1:0] len);
    uop_t a, b;
    int unsigned hi;
    logic [32:0] lo;
    a = '{rd: rd, rs1: rs1, rs2: rs2, opcode: opc, funct3: f3, funct7: f7, imm: imm,
          first: 1'b1, last: 1'b1, len: len, auipc: 1'b0};
    if (opc == 5'd2 && f7 <= 7'd4) begin
      b = '{rd: rd, rs1: rd, rs2: 5'd0, opcode: 5'd0, funct3: f3, funct7: 7'd0, imm: 33'd0,
            first: 1'b0, last: 1'b1, len: len, auipc: 1'b0};
      a.last = 1'b0;
      a.len  = 2'd0;
      if (f7 == 7'd0) begin
        hi = (int'(imm >> 12) + int'(imm[11])) % (1 << 21);
        lo = {21'd0, imm[11:0]};
        if (imm[11]) lo = lo - 33'h1000;   // negative low part, two's complement in 33 bits
        a.opcode = 5'd5; a.rs1 = 5'd0; a.rs2 = 5'd0; a.auipc = 1'b1;
        a.imm    = 33'(hi) << 12;
        b.imm    = lo;
      end else begin
        a.opcode = 5'd12; a.imm = 33'd0;
        a.funct7 = (f7 == 7'd1) ? 7'd0 : 7'd16;
        a.funct3 = (f7 == 7'd1) ? 3'd0 : 3'(2 * (f7 - 7'd1));
      end
      q.push_back(a);
      q.push_back(b);
    end else begin
      q.push_back(a);
    end
  endfunction

  task automatic check_outputs();
    uop_t act, exp;
    chk("out_valid", 128'(out_valid), 128'(q.size() > 0));
    if (q.size() > 0) begin
      exp = q[0];
      act = '{rd: out_rd, rs1: out_rs1, rs2: out_rs2, opcode: out_opcode, funct3: out_funct3,
              funct7: out_funct7, imm: out_imm, first: out_first, last: out_last,
              len: out_len_half_minus_one, auipc: exp.auipc};
      if (exp.auipc) begin
        act.funct3 = 3'd0; act.funct7 = 7'd0; exp.funct3 = 3'd0; exp.funct7 = 7'd0;
      end
      chk("uop", 128'(act), 128'(exp));
    end
  endtask

  // One clock: called at a falling edge with inputs already driven.
  task automatic cycle();
    logic exp_rdy;
    #1;
    exp_rdy = !flush && (q.size() < 2) && (q.size() == 0 || out_ready);
    chk("in_ready", 128'(in_ready), 128'(exp_rdy));
    if (q.size() > 0 && out_ready) void'(q.pop_front());
    if (flush) q.delete();
    else if (in_valid && exp_rdy)
      model_push(in_rd, in_rs1, in_rs2, in_opcode, in_funct3, in_funct7, in_imm, in_len_half_minus_one);
    @(posedge clock);
    @(negedge clock);
    check_outputs();
  endtask

  task automatic drive(input logic [4:0] opc, input logic [6:0] f7, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [32:0] imm, input logic [1:0] len);
    in_valid = 1'b1; in_opcode = opc; in_funct7 = f7; in_rd = rd; in_rs1 = rs1;
    in_rs2 = rs2; in_funct3 = f3; in_imm = imm; in_len_half_minus_one = len;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_opcode = '0; in_funct3 = '0;
    in_funct7 = '0; in_imm = '0; in_len_half_minus_one = '0;
    #12;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_payload", 128'({out_rd, out_rs1, out_rs2, out_opcode, out_funct3, out_funct7, out_imm,
                             out_len_half_minus_one}), 128'(0));
    chk("rst_first_last", 128'({out_first, out_last}), 128'(0));
    reset_n = 1'b1;
    @(negedge clock);
    #1 chk("rst_in_ready", 128'(in_ready), 128'(1));

    // Pass-through addi.
    drive(5'b00100, 7'd0, 5'd5, 5'd1, 5'd0, 3'd0, 33'h7, 2'd1);
    cycle();
    in_valid = 1'b0;
    chk("addi_fields", 128'({out_valid, out_opcode, out_rd, out_imm, out_first, out_last, out_len_half_minus_one}),
        128'({1'b1, 5'b00100, 5'd5, 33'h7, 1'b1, 1'b1, 2'd1}));
    cycle();

    // ld.pc: auipc then load with sign-extended low part.
    drive(5'b00010, 7'd0, 5'd10, 5'd0, 5'd0, 3'b011, 33'h0_0000_1800, 2'd2);
    cycle();
    in_valid = 1'b0;
    chk("ldpc_uop1", 128'({out_opcode, out_rd, out_imm, out_first, out_last, out_len_half_minus_one}),
        128'({5'b00101, 5'd10, 33'h0_0000_2000, 1'b1, 1'b0, 2'd0}));
    cycle();
    chk("ldpc_uop2", 128'({out_opcode, out_rd, out_rs1, out_funct3, out_imm, out_first, out_last, out_len_half_minus_one}),
        128'({5'b00000, 5'd10, 5'd10, 3'b011, 33'h1_FFFF_F800, 1'b0, 1'b1, 2'd2}));
    cycle();

    // ld.sh2add, with an addi waiting behind it that must stall one cycle.
    drive(5'b00010, 7'b0000011, 5'd3, 5'd4, 5'd5, 3'b010, 33'h0, 2'd1);
    cycle();
    chk("sh2add_uop1", 128'({out_opcode, out_funct3, out_funct7, out_rd, out_rs1, out_rs2, out_first}),
        128'({5'b01100, 3'b100, 7'b0010000, 5'd3, 5'd4, 5'd5, 1'b1}));
    drive(5'b00100, 7'd0, 5'd7, 5'd2, 5'd0, 3'd0, 33'h3, 2'd0);
    #1 chk("sh2add_stall", 128'(in_ready), 128'(0));
    cycle();
    chk("sh2add_uop2", 128'({out_opcode, out_rd, out_rs1, out_rs2, out_imm, out_last}),
        128'({5'b00000, 5'd3, 5'd3, 5'd0, 33'h0, 1'b1}));
    cycle();
    in_valid = 1'b0;
    chk("after_sh2add", 128'({out_opcode, out_rd}), 128'({5'b00100, 5'd7}));
    cycle();

    // Backpressure on ld.add.
    drive(5'b00010, 7'd1, 5'd8, 5'd9, 5'd11, 3'b010, 33'h55, 2'd3);
    cycle();
    in_valid = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_in_ready", 128'(in_ready), 128'(0));
      cycle();
      chk("bp_uop1", 128'({out_valid, out_opcode, out_funct3, out_funct7, out_imm, out_first}),
          128'({1'b1, 5'b01100, 3'b000, 7'd0, 33'h0, 1'b1}));
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_uop2", 128'({out_opcode, out_rd, out_rs1, out_last, out_len_half_minus_one}),
        128'({5'b00000, 5'd8, 5'd8, 1'b1, 2'd3}));
    cycle();

    // Flush while uop1 of ld.pc is held; an op offered during flush is ignored.
    drive(5'b00010, 7'd0, 5'd12, 5'd0, 5'd0, 3'b010, 33'h0_0000_0123, 2'd1);
    cycle();
    out_ready = 1'b0;
    flush = 1'b1;
    drive(5'b00100, 7'd0, 5'd1, 5'd1, 5'd0, 3'd0, 33'h1, 2'd0);
    cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_valid", 128'(out_valid), 128'(0));
    #1 chk("flush_in_ready", 128'(in_ready), 128'(1));
    for (int i = 0; i < 3; i++) cycle();

    // Asynchronous reset while a uop2 is pending.
    drive(5'b00010, 7'd4, 5'd6, 5'd7, 5'd8, 3'b011, 33'h0, 2'd0);
    cycle();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #3 reset_n = 1'b0;
    #1 chk("arst_valid", 128'(out_valid), 128'(0));
    q.delete();
    #2 reset_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clock);
    check_outputs();
    drive(5'b00100, 7'd0, 5'd9, 5'd3, 5'd0, 3'd1, 33'h1_0000_0001, 2'd2);
    cycle();
    in_valid = 1'b0;
    chk("arst_pass", 128'({out_valid, out_rd, out_imm, out_first, out_last}),
        128'({1'b1, 5'd9, 33'h1_0000_0001, 1'b1, 1'b1}));
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 39) == 0);
      in_opcode = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b00010;
      in_funct7 = ($urandom_range(0, 4) == 0) ? 7'($urandom) : 7'($urandom_range(0, 5));
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_funct3 = 3'($urandom);
      in_imm    = {1'($urandom), 32'($urandom)};
      in_len_half_minus_one = 2'($urandom);
      cycle();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_mop_crack.md
# rv_mop_crack

Macro-op cracker: the inverse of macro-op fusion. It accepts one decoded op per handshake. Fused `OpCode_Zarnavion` ops (ld.pc, ld.add, ld.sh1add, ld.sh2add, ld.sh3add) are re-expanded into their original two-uop sequence. Every other op passes through unchanged as a single uop. The block sits between decode/fusion and an execute backend that lacks fused-op datapaths. It is registered, with valid/ready handshakes on both sides.

## Interface
- No parameters.
- `clock` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `flush` input 1: synchronous kill of all held state.
- `in_valid` input 1, `in_ready` output 1: upstream handshake.
- `in_rd`, `in_rs1`, `in_rs2` input 5 each: decoded register fields.
- `in_opcode` input 5, `in_funct3` input 3, `in_funct7` input 7: decoded op fields.
- `in_imm` input 33: sign-carrying immediate.
- `in_len_half_minus_one` input 2: instruction-length tag, carried to the last uop.
- `out_valid` output 1, `out_ready` input 1: downstream handshake.
- `out_rd`, `out_rs1`, `out_rs2` output 5, `out_opcode` output 5, `out_funct3` output 3, `out_funct7` output 7, `out_imm` output 33: uop fields.
- `out_first` output 1, `out_last` output 1: uop position. Pass-through uops assert both.
- `out_len_half_minus_one` output 2: equals the input tag on the last uop, `2'b00` on a non-last uop.

## Operation
- Crack rules apply when `in_opcode == 5'b00010`. Uop1 uses `rd = in_rd`. Uop2 is `opcode 5'b00000` (load), `rd = rs1 = in_rd`, `rs2 = 0`, `funct3 = in_funct3`, `funct7 = 0`.
- **funct7 0000000 (ld.pc):**
  - Uop1 is auipc: `opcode 5'b00101`, `rs1 = rs2 = 0`, `imm = {in_imm[32:12] + in_imm[11], 12'b0}`, with 21-bit add and wrap.
  - Uop2 `imm = sign-extend(in_imm[11:0])` to 33 bits.
- **funct7 0000001 (ld.add):** uop1 is add: `opcode 5'b01100`, `funct3 000`, `funct7 0000000`, `rs1`/`rs2` from input, `imm = 0`. Uop2 `imm = 0`.
- **funct7 0000010 / 0000011 / 0000100 (ld.sh1add / sh2add / sh3add):** uop1 is `opcode 5'b01100`, `funct7 0010000`, `funct3` 010 / 100 / 110 respectively. All other fields match ld.add.
- **Any other funct7 with opcode 00010, and every other opcode:** single pass-through uop with all fields copied verbatim, `out_first = out_last = 1`.
- No special handling for `in_rd == 0`: the op is cracked identically.
- **State:** output register (`out_valid` plus payload) and a second-uop register (`pending` plus payload).
- **FSM:**
  - IDLE (`pending = 0`) → SECOND on accepting a crackable op.
  - SECOND → IDLE when uop1 leaves the output register and uop2 is loaded into it.
- `in_ready = !flush && !pending && (!out_valid || out_ready)`.
- **Output register load priority each cycle:**
  1. `flush`: clear `out_valid` and `pending`.
  2. `pending` and (`!out_valid` or `out_ready`): load uop2, clear `pending`.
  3. `in_valid && in_ready`: load uop1 or the pass-through uop. Set `pending` if the op is crackable.
  4. `out_ready`: clear `out_valid`.
- Output payload is stable while `out_valid && !out_ready`.

## Timing
- **Reset (asynchronous, on `reset_n` low):** `out_valid = 0`, `pending = 0`, all output payload 0, `out_first = out_last = 0`, `in_ready = 1` once `reset_n` is high.
- **Latency:** 1 cycle from input handshake to `out_valid`.
- **Pass-through throughput:** 1 op/cycle with `out_ready` held high.
- **Cracked op:** uop1 in cycle N+1, uop2 in cycle N+2 if `out_ready` is high. `in_ready` is 0 during cycle N+1, so the next op's uop appears in cycle N+3.
- **Backpressure:** with `out_ready` low, nothing advances and `pending` holds. Uop2 never overtakes uop1.
- **Flush:** takes effect at the next edge. A pending uop2 is discarded. An input presented in the flush cycle is not accepted (`in_ready = 0`).
- **Reset mid-crack:** `pending` is discarded immediately and uop2 is never emitted.

## Test plan
- **Pass-through:** `in addi` (opcode 00100, rd 5, imm 0x7) with `out_ready = 1` → next cycle one uop, identical fields, `first = last = 1`, `len` copied.
- **ld.pc:** `rd 10`, `funct3 011`, `imm 0x0_0000_1800` → auipc `rd 10`, `imm 0x0_0000_2000` (first); then load `rd 10`, `rs1 10`, `funct3 011`, `imm 0x1_FFFF_F800` (last).
- **ld.sh2add:** `rd 3`, `rs1 4`, `rs2 5`, `funct3 010` → uop1 `opcode 01100`, `funct3 100`, `funct7 0010000`, `rs1 4`, `rs2 5`; uop2 load `rs1 3`, `imm 0`. `in_ready` is 0 in the cycle between.
- **Backpressure:** hold `out_ready = 0` for 5 cycles after ld.add is accepted → uop1 held stable, `in_ready = 0`. On release, uop1 then uop2 appear on consecutive cycles.
- **Flush:** assert `flush` while uop1 of ld.pc is at the output → next cycle `out_valid = 0`, uop2 never appears, `in_ready = 1`.
- **Reset:** pulse `reset_n` low asynchronously while in SECOND → `out_valid = 0` immediately. After release, the next pass-through op works normally.
